// File: rtl/iter_sched_pkg.sv
// iter_sched_pkg: shared state encoding, default parameters and round-robin pick helper.
package iter_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 1;
    localparam int CNT_W_DEF = 4;
    localparam int MAX_REQ   = 32;
    localparam int IDX_W     = 5;
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;
    // Scanning from the far end down means the nearest valid index after ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [IDX_W-1:0] ptr, input int n);
        pick_t            p;
        logic [IDX_W-1:0] j;
        p = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            j = IDX_W'((int'(ptr) + k) % n);
            if (k <= n && valid[j]) begin
                p.found = 1'b1;
                p.idx   = j;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/iter_not_scheduler_not_stage.sv
// not_stage: the shared combinational bitwise-NOT datapath.
module not_stage #(
    parameter int W = 1
) (
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);
    assign out_o = ~in_i;
endmodule

// File: rtl/iter_not_scheduler.sv
// iter_not_scheduler: round-robin sequencer sharing one NOT stage among N_REQ requesters.
// ITER_SCHED_BACK_TO_BACK_EN lets a new request be accepted on the response-handshake edge.
module iter_not_scheduler
    import iter_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*W-1:0]     req_data,
    input  logic [N_REQ*CNT_W-1:0] req_iter,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);
    state_t            state_q, state_d;
    logic [W-1:0]      acc_q, acc_d, acc_not;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d, g;
    logic [W-1:0]      data_a [N_REQ];
    logic [CNT_W-1:0]  iter_a [N_REQ];
    pick_t             pick;
    logic              arb_en, grant;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_a[i] = req_data[i*W +: W];
        assign iter_a[i] = req_iter[i*CNT_W +: CNT_W];
    end

    not_stage #(.W(W)) u_not (.in_i(acc_q), .out_o(acc_not));

    assign pick = rr_pick(MAX_REQ'(req_valid), IDX_W'(ptr_q), N_REQ);
    assign g    = ID_W'(pick.idx);
`ifdef ITER_SCHED_BACK_TO_BACK_EN
    assign arb_en = rst && (state_q == IDLE || (state_q == RESP && rsp_ready));
`else
    assign arb_en = rst && state_q == IDLE;
`endif
    assign grant     = arb_en && pick.found;
    assign req_ready = grant ? N_REQ'(1) << g : '0;
    assign rsp_valid = state_q == RESP;
    assign rsp_data  = rsp_valid ? acc_q : '0;
    assign rsp_id    = rsp_valid ? id_q : '0;
    assign busy      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (grant) begin
            acc_d   = data_a[g];
            cnt_d   = iter_a[g];
            id_d    = g;
            ptr_d   = g;
            state_d = iter_a[g] != '0 ? RUN : RESP;
        end else if (state_q == RUN) begin
            acc_d   = acc_not;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = cnt_q == CNT_W'(1) ? RESP : RUN;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule
